// File: rtl/capture_ctrl.sv
// Capture sequencer for the logic-analyzer sample RAM: circular write pointer,
// pre-trigger fill, channel arming, AND-trigger and post-trigger count.
module capture_ctrl #(
  parameter int unsigned DEPTH = 384,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture_start,
  input  logic          capture_clr,
  input  logic [AW-1:0] trig_pos,
  input  logic          smpl_en,
  input  logic [4:0]    ch_trig,
  output logic          armed,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic          triggered,
  output logic [AW-1:0] trig_addr,
  output logic          capture_done
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] tp_q, tp_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] waddr_d, trig_addr_d;
  logic [AW-1:0] tp_sat;
  logic          triggered_d;

  assign tp_sat = (trig_pos > LAST) ? LAST : trig_pos;
  assign we     = smpl_en & ((state_q == PRE) | (state_q == ARMED) | (state_q == POST));

  // Next-state logic; cnt_q counts down the writes remaining in PRE/POST minus one
  always_comb begin
    state_d     = state_q;
    tp_d        = tp_q;
    cnt_d       = cnt_q;
    waddr_d     = waddr;
    trig_addr_d = trig_addr;
    triggered_d = triggered;

    if (we) begin
      waddr_d = (waddr == LAST) ? '0 : waddr + AW'(1);
    end

    if (capture_clr) begin
      state_d     = IDLE;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture_start) begin
            tp_d    = tp_sat;
            cnt_d   = LAST - tp_sat;
            waddr_d = '0;
            state_d = PRE;
          end
        end
        PRE: begin
          if (smpl_en) begin
            if (cnt_q == '0) state_d = ARMED;
            else             cnt_d   = cnt_q - AW'(1);
          end
        end
        ARMED: begin
          if (smpl_en && (&ch_trig)) begin
            trig_addr_d = waddr;
            triggered_d = 1'b1;
            if (tp_q == '0) begin
              state_d = DONE;
            end else begin
              cnt_d   = tp_q - AW'(1);
              state_d = POST;
            end
          end
        end
        POST: begin
          if (smpl_en) begin
            if (cnt_q == '0) state_d = DONE;
            else             cnt_d   = cnt_q - AW'(1);
          end
        end
        DONE:    ;
        default: state_d = IDLE;
      endcase
    end
  end

  // armed and capture_done come straight off flops so downstream clears never glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tp_q         <= '0;
      cnt_q        <= '0;
      waddr        <= '0;
      trig_addr    <= '0;
      triggered    <= 1'b0;
      armed        <= 1'b0;
      capture_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      tp_q         <= tp_d;
      cnt_q        <= cnt_d;
      waddr        <= waddr_d;
      trig_addr    <= trig_addr_d;
      triggered    <= triggered_d;
      armed        <= (state_d == ARMED);
      capture_done <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl: directed literal scenarios plus
// randomized traffic compared every cycle against a behavioural model.
module tb_capture_ctrl;

  localparam int unsigned D  = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          capture_start = 1'b0;
  logic          capture_clr = 1'b0;
  logic          smpl_en = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic [3:0]    trig_pos2 = '0;
  logic [4:0]    ch_trig = '0;

  logic          armed, we, triggered, capture_done;
  logic [AW-1:0] waddr, trig_addr;
  logic          armed2, we2, triggered2, done2;
  logic [3:0]    waddr2, trig_addr2;

  capture_ctrl #(.DEPTH(D), .AW(AW)) dut (
    .clk(clk), .rst(rst), .capture_start(capture_start), .capture_clr(capture_clr),
    .trig_pos(trig_pos), .smpl_en(smpl_en), .ch_trig(ch_trig),
    .armed(armed), .we(we), .waddr(waddr), .triggered(triggered),
    .trig_addr(trig_addr), .capture_done(capture_done)
  );

  capture_ctrl #(.DEPTH(8), .AW(4)) dut2 (
    .clk(clk), .rst(rst), .capture_start(capture_start), .capture_clr(capture_clr),
    .trig_pos(trig_pos2), .smpl_en(smpl_en), .ch_trig(ch_trig),
    .armed(armed2), .we(we2), .waddr(waddr2), .triggered(triggered2),
    .trig_addr(trig_addr2), .capture_done(done2)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Behavioural model: phase 0 idle, 1 pre-fill, 2 armed, 3 post-fill, 4 done
  int m_ph = 0, m_tp = 0, m_wa = 0, m_ta = 0, m_left = 0;
  bit m_trg = 1'b0;

  always @(posedge clk) begin
    bit w;
    if (rst) begin
      m_ph = 0; m_wa = 0; m_ta = 0; m_trg = 1'b0;
    end else begin
      w = smpl_en && (m_ph >= 1) && (m_ph <= 3);
      if (capture_clr) begin
        m_ph = 0; m_trg = 1'b0;
      end else begin
        case (m_ph)
          0: if (capture_start) begin
               m_tp   = (int'(trig_pos) > int'(D) - 1) ? int'(D) - 1 : int'(trig_pos);
               m_left = int'(D) - m_tp;
               m_wa   = 0;
               m_ph   = 1;
             end
          1: if (w) begin
               m_left--;
               if (m_left == 0) m_ph = 2;
             end
          2: if (w && ch_trig == 5'h1F) begin
               m_ta = m_wa; m_trg = 1'b1; m_left = m_tp;
               m_ph = (m_tp == 0) ? 4 : 3;
             end
          3: if (w) begin
               m_left--;
               if (m_left == 0) m_ph = 4;
             end
          default: ;
        endcase
      end
      if (w) m_wa = (m_wa + 1) % int'(D);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("armed", 32'(armed), 32'(m_ph == 2));
      chk("we", 32'(we), 32'(smpl_en && m_ph >= 1 && m_ph <= 3));
      chk("waddr", 32'(waddr), 32'(m_wa));
      chk("triggered", 32'(triggered), 32'(m_trg));
      chk("trig_addr", 32'(trig_addr), 32'(m_ta));
      chk("capture_done", 32'(capture_done), 32'(m_ph == 4));
    end
  end

  initial begin
    int exp_wa [9];
    exp_wa = '{0, 1, 2, 3, 4, 5, 6, 7, 0};

    run(2);
    rst = 1'b0;
    chk("reset_armed", 32'(armed), 0);
    chk("reset_waddr", 32'(waddr), 0);
    chk("reset_done", 32'(capture_done), 0);
    cmp_on = 1'b1;

    // tp=3, trigger held high: PRE 0..4, trigger at 5, POST 6,7,0
    trig_pos = 3'd3; smpl_en = 1'b1; ch_trig = 5'h1F; capture_start = 1'b1;
    tick();
    capture_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk("t1_waddr", 32'(waddr), 32'(exp_wa[i]));
      chk("t1_we", 32'(we), 1);
      chk("t1_armed", 32'(armed), 32'(i == 5));
      tick();
    end
    chk("t1_done", 32'(capture_done), 1);
    chk("t1_trig_addr", 32'(trig_addr), 5);
    chk("t1_we_done", 32'(we), 0);

    // tp=0: eight PRE writes, trigger at addr 0, straight to DONE
    capture_clr = 1'b1; tick(); capture_clr = 1'b0;
    trig_pos = 3'd0; capture_start = 1'b1; tick(); capture_start = 1'b0;
    run(8);
    chk("t2_armed", 32'(armed), 1);
    chk("t2_waddr", 32'(waddr), 0);
    tick();
    chk("t2_done", 32'(capture_done), 1);
    chk("t2_trig_addr", 32'(trig_addr), 0);
    capture_start = 1'b1; tick(); capture_start = 1'b0;
    chk("t2_start_in_done", 32'(capture_done), 1);

    // tp=3 with no trigger for 20 strobes, then trigger without a strobe
    capture_clr = 1'b1; tick(); capture_clr = 1'b0;
    trig_pos = 3'd3; ch_trig = 5'h00; capture_start = 1'b1; tick(); capture_start = 1'b0;
    run(5);
    run(20);
    chk("t3_done", 32'(capture_done), 0);
    chk("t3_waddr_wrap", 32'(waddr), 1);
    chk("t3_armed", 32'(armed), 1);
    ch_trig = 5'h1F; smpl_en = 1'b0;
    run(2);
    chk("t3_no_strobe_trig", 32'(triggered), 0);
    smpl_en = 1'b1;
    tick();
    chk("t3_triggered", 32'(triggered), 1);
    chk("t3_trig_addr", 32'(trig_addr), 1);
    chk("t3_post_armed", 32'(armed), 0);

    // clear during POST wins over a simultaneous start
    capture_clr = 1'b1; capture_start = 1'b1; tick();
    capture_clr = 1'b0; capture_start = 1'b0;
    chk("t4_armed", 32'(armed), 0);
    chk("t4_we", 32'(we), 0);
    chk("t4_done", 32'(capture_done), 0);
    chk("t4_trig_addr_hold", 32'(trig_addr), 1);

    // reset while ARMED
    ch_trig = 5'h00; capture_start = 1'b1; tick(); capture_start = 1'b0;
    run(5);
    chk("t5_armed_pre_rst", 32'(armed), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_armed", 32'(armed), 0);
    chk("t5_we", 32'(we), 0);
    chk("t5_waddr", 32'(waddr), 0);
    chk("t5_trig_addr", 32'(trig_addr), 0);

    // trig_pos clamp on a 4-bit pointer: 9 -> 7, PRE is one write
    trig_pos = 3'd7; trig_pos2 = 4'd9; capture_start = 1'b1; tick(); capture_start = 1'b0;
    chk("t6_we2", 32'(we2), 1);
    chk("t6_armed2_pre", 32'(armed2), 0);
    tick();
    chk("t6_armed2", 32'(armed2), 1);
    chk("t6_waddr2", 32'(waddr2), 1);
    chk("t6_armed", 32'(armed), 1);
    capture_clr = 1'b1; tick(); capture_clr = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      smpl_en       = ($urandom_range(0, 99) < 75);
      ch_trig       = ($urandom_range(0, 99) < 25) ? 5'h1F : 5'($urandom);
      capture_start = ($urandom_range(0, 99) < 10);
      capture_clr   = ($urandom_range(0, 99) < 2);
      rst           = ($urandom_range(0, 999) < 5);
      trig_pos      = 3'($urandom);
      trig_pos2     = 4'($urandom);
      tick();
    end
    capture_start = 1'b0; capture_clr = 1'b0; rst = 1'b0;
    tick();
    cmp_on = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
